// File: rtl/parity_data_beh_if.sv
// Byte-wide parity bus: data word plus received parity in, computed parity
// and error status out. The master drives the word, the slave checks it.
interface parity_data_beh_if;
    logic [7:0] data;
    logic       par_in;
    logic       chk_en;
    logic       pe;
    logic       par_err;
    logic       err_sticky;
    logic [7:0] err_cnt;

    modport master (
        output data,
        output par_in,
        output chk_en,
        input  pe,
        input  par_err,
        input  err_sticky,
        input  err_cnt
    );

    modport slave (
        input  data,
        input  par_in,
        input  chk_en,
        output pe,
        output par_err,
        output err_sticky,
        output err_cnt
    );
endinterface

// File: rtl/parity_data_beh.sv
// Registered 8-bit parity generator/checker. Every cycle the parity of the
// sampled word is registered onto pe; when checking is enabled the received
// parity is compared and a one-cycle error flag, a sticky flag and a
// saturating mismatch counter are kept. All outputs come straight from flops.
module parity_data_beh #(
    parameter logic ODD_PARITY = 1'b0
) (
    input logic              clk,
    input logic              rst,
    parity_data_beh_if.slave bus
);

    // Counter increment that holds at the top value instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        if (cnt == 8'hFF) begin
            return cnt;
        end
        return cnt + 8'd1;
    endfunction

    // Stage p0: combinational parity and mismatch of the current sample.
    logic p_p0;
    logic mismatch_p0;

    assign p_p0        = (^bus.data) ^ ODD_PARITY;
    assign mismatch_p0 = bus.chk_en & (bus.par_in != p_p0);

    // Stage p1: registered outputs.
    logic       pe_p1;
    logic       par_err_p1;
    logic       err_sticky_p1;
    logic [7:0] err_cnt_p1;

    // Register parity and error status; reset clears everything, even pe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_p1         <= 1'b0;
            par_err_p1    <= 1'b0;
            err_sticky_p1 <= 1'b0;
            err_cnt_p1    <= 8'd0;
        end else begin
            pe_p1      <= p_p0;
            par_err_p1 <= mismatch_p0;
            if (mismatch_p0) begin
                err_sticky_p1 <= 1'b1;
                err_cnt_p1    <= sat_inc(err_cnt_p1);
            end
        end
    end

    assign bus.pe         = pe_p1;
    assign bus.par_err    = par_err_p1;
    assign bus.err_sticky = err_sticky_p1;
    assign bus.err_cnt    = err_cnt_p1;

endmodule

// File: tb/tb_parity_data_beh.sv
// Bench for parity_data_beh: an even-sense and an odd-sense instance see the
// same stimulus; a behavioural model built on $countones predicts each.
module tb_parity_data_beh;

    logic clk;
    logic rst;

    parity_data_beh_if bus_e ();
    parity_data_beh_if bus_o ();

    parity_data_beh #(.ODD_PARITY(1'b0)) dut_e (.clk(clk), .rst(rst), .bus(bus_e));
    parity_data_beh #(.ODD_PARITY(1'b1)) dut_o (.clk(clk), .rst(rst), .bus(bus_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = even sense, 1 = odd sense.
    logic m_pe     [2];
    logic m_err    [2];
    logic m_sticky [2];
    int   m_cnt    [2];

    function automatic logic ref_par(input logic [7:0] d, input logic odd);
        return logic'($countones(d) % 2) ^ odd;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, advance the model at the
    // rising edge, compare both instances just after it.
    task automatic step(input logic [7:0] d, input logic pin, input logic ce, input logic r);
        @(negedge clk);
        rst          = r;
        bus_e.data   = d;
        bus_e.par_in = pin;
        bus_e.chk_en = ce;
        bus_o.data   = d;
        bus_o.par_in = pin;
        bus_o.chk_en = ce;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_pe[k]     = 1'b0;
                m_err[k]    = 1'b0;
                m_sticky[k] = 1'b0;
                m_cnt[k]    = 0;
            end else begin
                m_pe[k]  = ref_par(d, logic'(k));
                m_err[k] = ce && (pin != m_pe[k]);
                if (m_err[k]) begin
                    m_sticky[k] = 1'b1;
                    if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
        #1;
        check("even_pe",     32'(bus_e.pe),         32'(m_pe[0]));
        check("even_perr",   32'(bus_e.par_err),    32'(m_err[0]));
        check("even_sticky", 32'(bus_e.err_sticky), 32'(m_sticky[0]));
        check("even_cnt",    32'(bus_e.err_cnt),    32'(m_cnt[0]));
        check("odd_pe",      32'(bus_o.pe),         32'(m_pe[1]));
        check("odd_perr",    32'(bus_o.par_err),    32'(m_err[1]));
        check("odd_sticky",  32'(bus_o.err_sticky), 32'(m_sticky[1]));
        check("odd_cnt",     32'(bus_o.err_cnt),    32'(m_cnt[1]));
    endtask

    initial begin
        logic [7:0] d;
        for (int k = 0; k < 2; k++) begin
            m_pe[k] = 1'b0; m_err[k] = 1'b0; m_sticky[k] = 1'b0; m_cnt[k] = 0;
        end
        rst = 1'b1;
        bus_e.data = 8'h00; bus_e.par_in = 1'b0; bus_e.chk_en = 1'b0;
        bus_o.data = 8'h00; bus_o.par_in = 1'b0; bus_o.chk_en = 1'b0;

        // Reset two cycles, then basic generation in both senses.
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_release_pe", 32'(bus_e.pe), 32'd0);
        step(8'b11101110, 1'b0, 1'b0, 1'b0);
        check("six_ones_even", 32'(bus_e.pe), 32'd0);
        check("six_ones_odd",  32'(bus_o.pe), 32'd1);
        step(8'b11111000, 1'b0, 1'b0, 1'b0);
        check("five_ones_even", 32'(bus_e.pe), 32'd1);
        check("five_ones_odd",  32'(bus_o.pe), 32'd0);
        for (int i = 0; i < 4; i++) step(8'b11111000, 1'b0, 1'b0, 1'b0);
        check("hold_even", 32'(bus_e.pe), 32'd1);
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        check("ff_odd", 32'(bus_o.pe), 32'd1);

        // Check pass then fail then disabled (even sense).
        step(8'h01, 1'b1, 1'b1, 1'b0);
        check("pass_perr", 32'(bus_e.par_err), 32'd0);
        check("pass_cnt",  32'(bus_e.err_cnt), 32'd0);
        step(8'h01, 1'b0, 1'b1, 1'b0);
        check("fail_perr",   32'(bus_e.par_err),    32'd1);
        check("fail_sticky", 32'(bus_e.err_sticky), 32'd1);
        check("fail_cnt",    32'(bus_e.err_cnt),    32'd1);
        step(8'h01, 1'b0, 1'b0, 1'b0);
        check("dis_perr",   32'(bus_e.par_err),    32'd0);
        check("dis_sticky", 32'(bus_e.err_sticky), 32'd1);
        check("dis_cnt",    32'(bus_e.err_cnt),    32'd1);

        // Saturation: 300 mismatching checks on the even instance.
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            step(d, ~ref_par(d, 1'b0), 1'b1, 1'b0);
            check("sat_perr", 32'(bus_e.par_err), 32'd1);
        end
        check("sat_cnt", 32'(bus_e.err_cnt), 32'd255);

        // Reset mid-operation with a simultaneous mismatch.
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(8'h03, 1'b1, 1'b1, 1'b0);
        check("pre_rst_cnt", 32'(bus_e.err_cnt), 32'd10);
        step(8'h03, 1'b1, 1'b1, 1'b1);
        check("rst_win_cnt",    32'(bus_e.err_cnt),    32'd0);
        check("rst_win_sticky", 32'(bus_e.err_sticky), 32'd0);
        check("rst_win_pe",     32'(bus_o.pe),         32'd0);
        step(8'h03, 1'b1, 1'b1, 1'b0);
        check("post_rst_cnt", 32'(bus_e.err_cnt), 32'd1);

        // Exhaustive sweep with matching parity on a freshly reset pair.
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            step(8'(i), ref_par(8'(i), 1'b0), 1'b1, 1'b0);
        end
        check("sweep_cnt", 32'(bus_e.err_cnt), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_data_beh.md
# parity_data_beh

Registered 8-bit parity generator/checker. Each clock it computes the parity bit of an 8-bit data word and presents it on `pe`. Optionally it compares a received parity bit against the computed one and keeps error status and a saturating error count. It sits on byte-wide datapaths, either to generate a parity bit for transmit or to check parity on receive.

## Interface
Parameters:
- `ODD_PARITY`, default 0, parity sense.
  - 0 = even parity: `pe` makes the total count of ones in {data, pe} even.
  - 1 = odd parity.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset.
- `data`  in  8  data word, sampled every rising edge.
- `par_in`  in  1  received parity bit, used only when `chk_en`=1.
- `chk_en`  in  1  check enable for the current `data`/`par_in`.
- `pe`  out  1  computed parity bit of `data` sampled at the last edge.
- `par_err`  out  1  one-cycle flag: last checked word had a parity mismatch.
- `err_sticky`  out  1  set on any mismatch; cleared only by `rst`.
- `err_cnt`  out  8  count of mismatches, saturating at 255.

## Operation
- Combinational parity: p = XOR-reduction of `data[7:0]`, XOR `ODD_PARITY`.
- On each rising edge with `rst`=1, all outputs go to 0: `pe`=0, `par_err`=0, `err_sticky`=0, `err_cnt`=0.
  - This holds regardless of `ODD_PARITY`.
  - Reset overrides every other input.
- On each rising edge with `rst`=0:
  - `pe` <= p. This is unconditional and does not depend on `chk_en`.
  - mismatch = `chk_en` & (`par_in` != p).
  - `par_err` <= mismatch.
  - If mismatch: `err_sticky` <= 1.
  - If mismatch and `err_cnt` < 255: `err_cnt` <= `err_cnt` + 1. At 255 it holds; there is no wrap.
- When `chk_en`=0, `par_in` is ignored. `par_err` returns to 0, and `err_sticky` and `err_cnt` hold.
- No handshake: every cycle is an independent sample, and back-to-back words are checked at full rate.
- X-free: all outputs are driven from flops with defined reset values.

## Timing
- Latency 1 clock: `data` present at edge N produces `pe` valid after edge N until edge N+1.
- `par_err` and `err_cnt`/`err_sticky` updates appear after the same edge at which the checked word is sampled.
- Reset asserted mid-stream: outputs clear at the first edge with `rst`=1. Normal operation resumes with the first edge at `rst`=0, using the `data` present at that edge.
- Simultaneous `rst`=1 and a mismatch: reset wins, counter stays 0.
- No combinational path from inputs to outputs.

## Test plan
- Reset and basic generation (`ODD_PARITY`=0).
  - Assert `rst` 2 cycles, then release with `data`=8'h00 → all outputs 0, and `pe`=0.
  - Then `data`=8'b11101110 (6 ones) → `pe`=0 after next edge.
  - Then `data`=8'b11111000 (5 ones) → `pe`=1 after next edge.
  - Hold 4 cycles → `pe` stays 1.
- Odd sense (`ODD_PARITY`=1): `data`=8'b11101110 → `pe`=1; `data`=8'b11111000 → `pe`=0; `data`=8'hFF → `pe`=1.
- Check pass and fail (`ODD_PARITY`=0).
  - `chk_en`=1, `data`=8'h01, `par_in`=1 → `par_err`=0, `err_cnt`=0.
  - Next cycle `par_in`=0 → `par_err`=1, `err_sticky`=1, `err_cnt`=1.
  - Next cycle `chk_en`=0 → `par_err`=0, `err_sticky`=1, `err_cnt`=1.
- Saturation: 300 consecutive mismatching checks → `err_cnt` reaches 255 and stays 255, and `par_err`=1 each cycle.
- Reset mid-operation: with `err_cnt`=10 and `err_sticky`=1, assert `rst` together with a mismatching check → next edge all outputs 0. After release, a new mismatch gives `err_cnt`=1.
- Exhaustive: sweep `data` 0–255 with `chk_en`=1 and `par_in` = the reference XOR-reduction → `pe` matches the reference every cycle and `err_cnt` stays 0.
